// File: rtl/ca2_q1_mux_with_assigning.sv
// rtl/ca2_q1_mux_with_assigning.sv - gate-delayed 4:1 mux with registered output and toggle counter
//
// Ports:
//   clk        rising-edge clock for the capture stage
//   rst_n      asynchronous active-low reset of the capture stage
//   a,b,c,d    data inputs selected by {s1,s0} = 00,01,10,11
//   s0, s1     select LSB / MSB
//   w          combinational mux output with modelled gate delays
//   w_q        w registered on clk
//   toggle_cnt number of w_q value changes since reset (wraps)
`timescale 1ns/1ns
module ca2_q1_mux_with_assigning #(
   parameter int T_NOT = 3,
   parameter int T_AND = 5,
   parameter int T_OR  = 7,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             s0,
   input  logic             s1,
   output logic             w,
   output logic             w_q,
   output logic [CNT_W-1:0] toggle_cnt
);

   logic s0_n;
   logic s1_n;
   logic ta;
   logic tb;
   logic tc;
   logic td;

   // Delays sit on each gate stage so the inverted select legs form the
   // longest path (T_NOT + T_AND + T_OR); select glitches are left visible.
   assign #T_NOT s0_n = ~s0;
   assign #T_NOT s1_n = ~s1;

   assign #T_AND ta = a & s1_n & s0_n;
   assign #T_AND tb = b & s1_n & s0;
   assign #T_AND tc = c & s1   & s0_n;
   assign #T_AND td = d & s1   & s0;

   assign #T_OR w = ta | tb | tc | td;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q        <= 1'b0;
         toggle_cnt <= '0;
      end else begin
         w_q <= w;
         // An unknown comparison is not true, so an X capture never counts.
         if (w != w_q) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ca2_q1_mux_with_assigning.sv
// tb/tb_ca2_q1_mux_with_assigning.sv - directed self-checking bench for ca2_q1_mux_with_assigning
`timescale 1ns/1ns
module tb_ca2_q1_mux_with_assigning;

   logic       clk;
   logic       rst_n;
   logic       a, b, c, d, s0, s1;
   logic       w;
   logic       w_q;
   logic [7:0] toggle_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       wq;
      logic [7:0] cnt;
   } cap_t;

   logic w_exp_q[$];
   cap_t cap_q[$];

   logic       exp_wq;
   logic [7:0] exp_cnt;

   ca2_q1_mux_with_assigning dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .s0         (s0),
      .s1         (s1),
      .w          (w),
      .w_q        (w_q),
      .toggle_cnt (toggle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one toggle of a, record the expected capture result, then check it.
   task automatic toggle_and_check(input string tag);
      cap_t e;
      @(negedge clk);
      a = ~a;
      exp_wq  = a;
      exp_cnt = exp_cnt + 8'd1;
      cap_q.push_back('{wq: exp_wq, cnt: exp_cnt});
      #70;
      if (cap_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = cap_q.pop_front();
         check({tag, "_wq"}, {31'd0, w_q}, {31'd0, e.wq});
         check({tag, "_cnt"}, {24'd0, toggle_cnt}, {24'd0, e.cnt});
      end
   endtask

   initial begin
      logic [5:0] v;
      logic       sel_val;
      rst_n = 1'b0;
      a = 1'b0; b = 1'b1; c = 1'b1; d = 1'b1; s1 = 1'b0; s0 = 1'b0;

      #1;
      check("reset_wq", {31'd0, w_q}, 32'd0);
      check("reset_cnt", {24'd0, toggle_cnt}, 32'd0);

      // Data path: 12 ns from a to w.
      #19;
      check("data_settled_w0", {31'd0, w}, 32'd0);
      a = 1'b1;
      #11;
      check("data_w_before_12", {31'd0, w}, 32'd0);
      #2;
      check("data_w_after_12", {31'd0, w}, 32'd1);

      // Inverted select leg, falling result: 15 ns.
      b = 1'b0; c = 1'b0; d = 1'b0;
      #30;
      check("inv_fall_start", {31'd0, w}, 32'd1);
      s0 = 1'b1;
      #14;
      check("inv_fall_before_15", {31'd0, w}, 32'd1);
      #2;
      check("inv_fall_after_15", {31'd0, w}, 32'd0);

      // Inverted select leg, rising result: 15 ns, still low at 12 ns.
      #30;
      s0 = 1'b0;
      #11;
      check("inv_rise_before_12", {31'd0, w}, 32'd0);
      #3;
      check("inv_rise_at_14", {31'd0, w}, 32'd0);
      #2;
      check("inv_rise_after_15", {31'd0, w}, 32'd1);

      // Sweep all 64 input combinations.
      for (int i = 0; i < 64; i++) begin
         v = 6'(i);
         {a, b, c, d, s1, s0} = v;
         case ({v[1], v[0]})
            2'b00:   sel_val = v[5];
            2'b01:   sel_val = v[4];
            2'b10:   sel_val = v[3];
            default: sel_val = v[2];
         endcase
         w_exp_q.push_back(sel_val);
         #70;
         check($sformatf("sweep_%0d", i), {31'd0, w}, {31'd0, w_exp_q.pop_front()});
      end

      // Capture stage.
      a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0; s1 = 1'b0; s0 = 1'b0;
      #70;
      @(negedge clk);
      rst_n   = 1'b1;
      exp_wq  = 1'b0;
      exp_cnt = 8'd0;
      for (int i = 0; i < 5; i++) toggle_and_check($sformatf("cap_%0d", i));

      // Mid-cycle asynchronous reset with w_q=1, toggle_cnt=5.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_wq", {31'd0, w_q}, 32'd0);
      check("async_rst_cnt", {24'd0, toggle_cnt}, 32'd0);
      check("async_rst_w", {31'd0, w}, 32'd1);

      // Release takes effect at the next rising edge.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_wq_hold", {31'd0, w_q}, 32'd0);
      @(posedge clk);
      #1;
      check("release_wq", {31'd0, w_q}, 32'd1);
      check("release_cnt", {24'd0, toggle_cnt}, 32'd1);
      exp_wq  = 1'b1;
      exp_cnt = 8'd1;

      // 255 more toggles: 256 changes since reset wraps the counter.
      for (int i = 0; i < 255; i++) toggle_and_check($sformatf("wrap_%0d", i));
      check("wrap_final_cnt", {24'd0, toggle_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
